// File: rtl/exp_lut_arbiter.sv
// Round-robin arbiter sharing one exp-scale LUT between NUM_REQ requesters, 2-stage in-order pipeline.
// Optional statistics counters enabled by defining EXP_LUT_ARB_STATS_EN.
module exp_lut_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [4*NUM_REQ-1:0]   req_exp_int,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [3:0]             lut_exp_int,
   input  logic [11:0]            lut_exp_scale,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [11:0]            rsp_exp_scale
`ifdef EXP_LUT_ARB_STATS_EN
   ,
   output logic [16*NUM_REQ-1:0]  grant_cnt,
   output logic [15:0]            stall_cnt,
   input  logic                   stats_clr
`endif
);

   logic           s1_valid_q, s1_valid_d;
   logic [IDW-1:0] s1_id_q, s1_id_d;
   logic [3:0]     s1_exp_q, s1_exp_d;
   logic           s2_valid_q, s2_valid_d;
   logic [IDW-1:0] s2_id_q, s2_id_d;
   logic [11:0]    s2_scale_q, s2_scale_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic           s1_accept, s2_accept;
   logic           found, grant;
   logic [IDW-1:0] winner, cand;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDW'(s);
   endfunction

   assign s2_accept = !s2_valid_q | rsp_ready;
   assign s1_accept = !s1_valid_q | s2_accept;

   // First valid requester at or after ptr wins; reset masks every grant.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_idx(ptr_q, k);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign grant = found & s1_accept & !rst;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[winner] = 1'b1;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_exp_d   = s1_exp_q;
      s2_valid_d = s2_valid_q;
      s2_id_d    = s2_id_q;
      s2_scale_d = s2_scale_q;
      ptr_d      = ptr_q;
      if (s1_accept) begin
         s1_valid_d = grant;
         if (grant) begin
            s1_id_d  = winner;
            s1_exp_d = req_exp_int[4*int'(winner) +: 4];
            ptr_d    = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
         end
      end
      // The LUT is combinational, so its result is captured in the cycle it is indexed.
      if (s2_accept) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_id_d    = s1_id_q;
            s2_scale_d = lut_exp_scale;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_exp_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
         s2_scale_q <= '0;
         ptr_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_exp_q   <= s1_exp_d;
         s2_valid_q <= s2_valid_d;
         s2_id_q    <= s2_id_d;
         s2_scale_q <= s2_scale_d;
         ptr_q      <= ptr_d;
      end
   end

   assign lut_exp_int   = s1_exp_q;
   assign rsp_valid     = s2_valid_q;
   assign rsp_id        = s2_id_q;
   assign rsp_exp_scale = s2_scale_q;

`ifdef EXP_LUT_ARB_STATS_EN
   logic [15:0] grant_cnt_q [NUM_REQ];
   logic [15:0] stall_cnt_q;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               grant_cnt_q[gi] <= '0;
            else if (stats_clr)
               grant_cnt_q[gi] <= '0;
            else if (req_valid[gi] && req_ready[gi] && grant_cnt_q[gi] != 16'hFFFF)
               grant_cnt_q[gi] <= grant_cnt_q[gi] + 16'd1;
         end
         assign grant_cnt[16*gi +: 16] = grant_cnt_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (stats_clr)
         stall_cnt_q <= '0;
      else if (s2_valid_q && !rsp_ready && stall_cnt_q != 16'hFFFF)
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
